sync_fifo_p: RTL and testbench
==============================

# sync_fifo_p

Parametrised synchronous FIFO for all single-clock buffering in the design. It is the successor to the fixed 8×32 FIFO and adds:
- configurable data width and depth,
- programmable almost-full/almost-empty thresholds,
- an exact fill-level output,
- sticky overflow/underflow error flags,
- a synchronous flush,
- an optional first-word-fall-through (FWFT) read mode.

## Interface
- DATA_WIDTH, default 32: width of each entry in bits.
- DEPTH, default 16: number of entries. Must be a power of two and ≥ 2.
- AF_THRESH, default DEPTH-2: almost_full asserts when level ≥ AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, default 2: almost_empty asserts when level ≤ AE_THRESH. Legal range 0..DEPTH-1.
- FWFT, default 0: 0 = registered read with one-cycle latency; 1 = first-word-fall-through.
- Derived widths: PTR_W = $clog2(DEPTH); LVL_W = $clog2(DEPTH+1).
- clk  input  1  single clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flush  input  1  synchronous clear of contents and error flags.
- write_en  input  1  push request.
- data_in  input  DATA_WIDTH  push data.
- read_en  input  1  pop request.
- data_out  output  DATA_WIDTH  read data.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- almost_full  output  1  level ≥ AF_THRESH.
- almost_empty  output  1  level ≤ AE_THRESH.
- level  output  LVL_W  number of stored entries.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH×DATA_WIDTH register array, write pointer, read pointer and level register.
  - Pointers are PTR_W bits wide and wrap from DEPTH-1 to 0 naturally.
  - The level register is LVL_W bits wide, so it can represent the value DEPTH.
- Accepted write: wr_ok = write_en & !full. The entry is written at the write pointer, and the write pointer increments.
- Accepted read: rd_ok = read_en & !empty. The read pointer increments.
- Level update:
  - +1 when only wr_ok.
  - −1 when only rd_ok.
  - Unchanged when both or neither.
- When full and both requests are asserted: the read is accepted, the write is rejected, and level becomes DEPTH-1.
- When empty and both requests are asserted: the write is accepted, the read is rejected, and level becomes 1.
- Status outputs full, empty, almost_full and almost_empty are combinational decodes of the registered level.
- Error flags:
  - overflow sets on write_en & full.
  - underflow sets on read_en & empty.
  - Each holds until reset or flush. A rejected access changes no other state.
- FWFT=0 read data: on rd_ok, data_out loads mem[rd_ptr] at the clock edge. Otherwise data_out holds its value.
- FWFT=1 read data: data_out = mem[rd_ptr] combinationally while !empty, and 0 while empty. read_en acknowledges (pops) the displayed word.
- Flush:
  - Pointers, level, overflow and underflow go to 0.
  - Any write_en/read_en in the same cycle is ignored and sets no flag.
  - Array contents are not cleared.
  - With FWFT=0, data_out holds its value.
- Priority order: reset > flush > normal operation.

## Timing
- Reset (reset low at a rising edge):
  - Pointers and level = 0; data_out = 0; overflow = underflow = 0.
  - Resulting outputs: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given AF_THRESH ≥ 1).
  - Array contents are undefined.
- Reset asserted mid-operation discards all contents at that edge. Accesses in the same cycle are ignored.
- Write-to-status latency: level, empty and full update one cycle after the accepted write's edge, i.e. they reflect the write from the next cycle onward.
- Write-to-read (FWFT=1): a word written into an empty FIFO appears on data_out in the cycle after the write edge.
- Write-to-read (FWFT=0): the first read_en may be issued in the cycle after the write edge; data_out is valid after that read's edge.
- No combinational path from write_en/read_en to any output, except data_out in FWFT mode, which depends only on registered state.
- Full throughput: one push and one pop per cycle, sustained indefinitely at any level strictly between 0 and DEPTH.

## Test plan
- Reset/fill/drain: apply reset, then write 0x1..0x10 (DEPTH=16).
  - Expect full=1 and level=16 after the 16th write, with almost_full first set at level 14.
  - Drain 16 reads; expect data_out = 0x1..0x10 in order (FWFT=0, one cycle after each read), then empty=1.
- Overflow/underflow: while full, assert write_en with 0xDEAD.
  - Expect overflow=1, level stays 16, and the 0xDEAD word is never read.
  - Drain, then read while empty; expect underflow=1. After flush, expect both flags 0.
- Simultaneous access at boundaries:
  - Full plus write+read: level becomes 15 and the oldest word is output.
  - Empty plus write+read of 0xA5: level becomes 1, underflow sets, and 0xA5 is read next.
- Wrap-around: 100 cycles of random push/pop with level held between 3 and 13; a scoreboard reference queue must match every output word and the level on every cycle.
- FWFT=1: write 0x77 into an empty FIFO.
  - Expect data_out = 0x77 on the next cycle with no read issued.
  - Pop it; expect data_out = 0 and empty = 1.
- Flush/reset mid-stream: with 5 entries held, assert flush together with write_en.
  - Expect level=0, empty=1, no overflow.
  - Repeat with reset low; expect data_out=0.

Source files
------------

// File: rtl/sync_fifo_p.sv
// Parametrised single-clock FIFO: exact fill level, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags, synchronous flush, optional FWFT read.
module sync_fifo_p #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         write_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         read_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status is decoded from the registered level only, so no request-to-status path.
  assign full         = (level == LVL_W'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LVL_W'(AF_THRESH));
  assign almost_empty = (level <= LVL_W'(AE_THRESH));

  assign wr_ok = write_en & ~full;
  assign rd_ok = read_en & ~empty;

  // Pointers, level and sticky error flags; reset beats flush beats normal operation.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_ok && !rd_ok) begin
        level <= level + LVL_W'(1);
      end else if (rd_ok && !wr_ok) begin
        level <= level - LVL_W'(1);
      end
      if (write_en && full)  overflow  <= 1'b1;
      if (read_en  && empty) underflow <= 1'b1;
    end
  end

  // Storage array carries no reset; contents survive flush.
  always_ff @(posedge clk) begin
    if (reset && !flush && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly from the array; zero when nothing is stored.
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;

      always_ff @(posedge clk) begin
        if (!reset) begin
          data_q <= '0;
        end else if (!flush && rd_ok) begin
          data_q <= mem[rd_ptr];
        end
      end

      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_p.sv
// Directed bench for sync_fifo_p: registered-read instance (DEPTH=16) and an FWFT instance (DEPTH=4).
module tb_sync_fifo_p;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        write_en, read_en;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  level;

  logic        f_flush, f_write_en, f_read_en;
  logic [31:0] f_data_in, f_data_out;
  logic        f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0]  f_level;

  int checks = 0;
  int errors = 0;

  sync_fifo_p #(.DATA_WIDTH(32), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_p #(.DATA_WIDTH(32), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) dut_fwft (
    .clk(clk), .reset(reset), .flush(f_flush), .write_en(f_write_en), .data_in(f_data_in),
    .read_en(f_read_en), .data_out(f_data_out), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    write_en = 1'b1; data_in = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic pop();
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_word;
  logic        w, r;

  initial begin
    reset = 1'b0; flush = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    f_flush = 1'b0; f_write_en = 1'b0; f_read_en = 1'b0; f_data_in = '0;
    #1;
    tick(); tick();
    reset = 1'b1;

    // Reset state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_dout", data_out, 32'd0);
    check("rst_flags", {30'd0, overflow, underflow}, 32'd0);

    // Fill 1..16; almost_full first at level 14
    for (int i = 1; i <= 16; i++) begin
      push(32'(i));
      check($sformatf("fill_level_%0d", i), 32'(level), 32'(i));
      check($sformatf("fill_af_%0d", i), 32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(full), 32'd1);

    // Write while full is rejected and flagged
    push(32'hDEAD);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd16);

    // Full with simultaneous write+read: read wins, oldest word out
    write_en = 1'b1; read_en = 1'b1; data_in = 32'h11;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    check("full_wr_rd_level", 32'(level), 32'd15);
    check("full_wr_rd_dout", data_out, 32'd1);

    for (int i = 2; i <= 16; i++) begin
      pop();
      check($sformatf("drain_%0d", i), data_out, 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_level", 32'(level), 32'd0);

    // Read while empty
    pop();
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_dout_hold", data_out, 32'd16);
    check("udf_level", 32'(level), 32'd0);

    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_flags", {30'd0, overflow, underflow}, 32'd0);

    // Empty with simultaneous write+read of 0xA5
    write_en = 1'b1; read_en = 1'b1; data_in = 32'hA5;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    check("empty_wr_rd_level", 32'(level), 32'd1);
    check("empty_wr_rd_udf", 32'(underflow), 32'd1);
    pop();
    check("empty_wr_rd_dout", data_out, 32'hA5);
    flush = 1'b1; tick(); flush = 1'b0;

    // Wrap-around with a reference queue, level held in 3..13
    for (int i = 0; i < 8; i++) begin
      exp_word = $urandom;
      push(exp_word);
      q.push_back(exp_word);
    end
    for (int c = 0; c < 100; c++) begin
      w = 1'($urandom_range(1));
      r = 1'($urandom_range(1));
      if (q.size() <= 3 && !w) r = 1'b0;
      if (q.size() >= 13 && !r) w = 1'b0;
      data_in = $urandom;
      write_en = w; read_en = r;
      exp_word = '0;
      if (r) exp_word = q.pop_front();
      if (w) q.push_back(data_in);
      tick();
      write_en = 1'b0; read_en = 1'b0;
      if (r) check($sformatf("wrap_dout_%0d", c), data_out, exp_word);
      check($sformatf("wrap_level_%0d", c), 32'(level), 32'(q.size()));
    end
    flush = 1'b1; tick(); flush = 1'b0;
    q.delete();

    // FWFT: word visible the cycle after the write, with no read
    f_write_en = 1'b1; f_data_in = 32'h77;
    tick();
    f_write_en = 1'b0;
    check("fwft_show", f_data_out, 32'h77);
    check("fwft_not_empty", 32'(f_empty), 32'd0);
    f_read_en = 1'b1; tick(); f_read_en = 1'b0;
    check("fwft_pop_dout", f_data_out, 32'd0);
    check("fwft_pop_empty", 32'(f_empty), 32'd1);
    f_write_en = 1'b1; f_data_in = 32'h10; tick();
    f_data_in = 32'h20; tick();
    f_write_en = 1'b0;
    check("fwft_head1", f_data_out, 32'h10);
    f_read_en = 1'b1; tick(); f_read_en = 1'b0;
    check("fwft_head2", f_data_out, 32'h20);
    check("fwft_level", 32'(f_level), 32'd1);

    // Flush with write_en: 6 in, 1 out, 5 held
    for (int i = 0; i < 6; i++) push(32'h31 + 32'(i));
    pop();
    check("pre_flush_dout", data_out, 32'h31);
    check("pre_flush_level", 32'(level), 32'd5);
    flush = 1'b1; write_en = 1'b1; data_in = 32'hBAD;
    tick();
    flush = 1'b0; write_en = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_dout_hold", data_out, 32'h31);

    // Reset with write_en mid-stream
    for (int i = 0; i < 5; i++) push(32'h50 + 32'(i));
    reset = 1'b0; write_en = 1'b1; data_in = 32'hBAD;
    tick();
    reset = 1'b1; write_en = 1'b0;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_dout", data_out, 32'd0);
    check("mid_rst_flags", {30'd0, overflow, underflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
